// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, flag bit
// positions, FSM state encoding and a helper classifying condition codes.
package branch_resolve_unit_pkg;

  // Condition codes carried on br_cond
  localparam logic [2:0] COND_BR   = 3'b000;  // always taken
  localparam logic [2:0] COND_BLTZ = 3'b001;  // taken on sign
  localparam logic [2:0] COND_BZ   = 3'b010;  // taken on zero
  localparam logic [2:0] COND_BNZ  = 3'b011;  // taken on !zero
  localparam logic [2:0] COND_BCY  = 3'b100;  // taken on carry
  localparam logic [2:0] COND_BNCY = 3'b101;  // taken on !carry
  localparam logic [2:0] COND_BL   = 3'b110;  // always taken, writes link
  localparam logic [2:0] COND_RSVD = 3'b111;  // never taken, no link

  // Bit positions inside the {sign,zero,carry} flag vector
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 0;

  // Outstanding-op counter limit and link return stride
  localparam logic [1:0]  OUT_CNT_MAX = 2'd3;
  localparam logic [31:0] LINK_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the branch outcome depends on ALU flags
  function automatic logic cond_needs_flags(input logic [2:0] cond);
    return !((cond == COND_BR) || (cond == COND_BL) || (cond == COND_RSVD));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// branch_cond_eval: purely combinational map from (condition code, flags)
// to (taken, link).
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o,
  output logic       link_o
);

  // Decode the condition code against the current flags
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    taken_o = 1'b0;
    link_o  = 1'b0;
    case (cond_i)
      COND_BR:   taken_o = 1'b1;
      COND_BLTZ: taken_o = flags_i[FLAG_SIGN];
      COND_BZ:   taken_o = flags_i[FLAG_ZERO];
      COND_BNZ:  taken_o = !flags_i[FLAG_ZERO];
      COND_BCY:  taken_o = flags_i[FLAG_CARRY];
      COND_BNCY: taken_o = !flags_i[FLAG_CARRY];
      COND_BL: begin
        taken_o = 1'b1;
        link_o  = 1'b1;
      end
      default: begin
        taken_o = 1'b0;
        link_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches against ALU flags.
// Tracks up to three outstanding flag-setting ALU ops; a flag-dependent
// branch waits until every op older than it has delivered its flags, then
// evaluates against the most recent flags. Results are registered and held
// until the consumer accepts them.
// Optional build macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters on stat_taken / stat_not_taken.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_issue,
  output logic        alu_issue_ready,
  input  logic        flag_valid,
  input  logic [2:0]  flag_in,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        res_link,
  output logic [31:0] res_link_addr
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] stat_taken,
  output logic [15:0] stat_not_taken
`endif
);

  state_e      state_q;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  wait_cnt_q;
  logic [2:0]  flag_q;
  logic [2:0]  cond_q;
  logic        res_valid_q;
  logic        res_taken_q;
  logic        res_link_q;
  logic [31:0] res_target_q;
  logic [31:0] res_link_addr_q;

  logic        issue_ok;
  logic        flag_ok;
  logic [2:0]  eval_cond;
  logic        eval_taken;
  logic        eval_link;

  // An issue is dropped when the counter is full; a flag with nothing
  // outstanding is stray and does not underflow the counter.
  assign issue_ok = alu_issue && (out_cnt_q != OUT_CNT_MAX);
  assign flag_ok  = flag_valid && (out_cnt_q != 2'd0);

  assign alu_issue_ready = (out_cnt_q != OUT_CNT_MAX);
  assign br_ready        = (state_q == ST_IDLE) && !rst;

  // At accept the incoming code is evaluated; while waiting, the captured one
  assign eval_cond = (state_q == ST_IDLE) ? br_cond : cond_q;

  branch_cond_eval u_cond_eval (
    .cond_i  (eval_cond),
    .flags_i (flag_q),
    .taken_o (eval_taken),
    .link_o  (eval_link)
  );

  // Next outstanding count: simultaneous issue and retire cancel out
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({issue_ok, flag_ok})
      2'b10:   out_cnt_d = out_cnt_q + 2'd1;
      2'b01:   out_cnt_d = out_cnt_q - 2'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Outstanding counter and latest-flags register, independent of the FSM
  // NOTE: every register here is control state, so all of them take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= 2'd0;
      flag_q    <= 3'b000;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of its peers.
      out_cnt_q <= out_cnt_d;
      if (flag_valid) begin
        flag_q <= flag_in;
      end
    end
  end

  // Branch FSM: accept, wait for older flags, present registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wait_cnt_q      <= 2'd0;
      cond_q          <= COND_BR;
      res_valid_q     <= 1'b0;
      res_taken_q     <= 1'b0;
      res_link_q      <= 1'b0;
      res_target_q    <= 32'd0;
      res_link_addr_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            // An op issuing in this same cycle is younger and is not waited on
            cond_q          <= br_cond;
            wait_cnt_q      <= out_cnt_q;
            res_target_q    <= br_pc + br_offset;
            res_link_addr_q <= br_pc + LINK_STRIDE;
            res_link_q      <= eval_link;
            if (!cond_needs_flags(br_cond) || (out_cnt_q == 2'd0)) begin
              state_q     <= ST_RESP;
              res_valid_q <= 1'b1;
              res_taken_q <= eval_taken;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // flag_q already holds the last required flags once the count hits 0
          if (wait_cnt_q == 2'd0) begin
            state_q     <= ST_RESP;
            res_valid_q <= 1'b1;
            res_taken_q <= eval_taken;
          end else if (flag_valid) begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid     = res_valid_q;
  assign res_taken     = res_taken_q;
  assign res_target    = res_target_q;
  assign res_link      = res_link_q;
  assign res_link_addr = res_link_addr_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken_q;
  logic [15:0] stat_not_taken_q;

  // Saturating outcome counters, bumped on each accepted resolution
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken_q     <= 16'd0;
      stat_not_taken_q <= 16'd0;
    end else if (res_valid_q && res_ready) begin
      if (res_taken_q) begin
        if (stat_taken_q != 16'hFFFF) begin
          stat_taken_q <= stat_taken_q + 16'd1;
        end
      end else begin
        if (stat_not_taken_q != 16'hFFFF) begin
          stat_not_taken_q <= stat_not_taken_q + 16'd1;
        end
      end
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. A transaction-level model
// (outstanding-op count, latest flags, condition truth table) predicts the
// cycle in which each resolution appears and its contents.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_issue;
  logic        alu_issue_ready;
  logic        flag_valid;
  logic [2:0]  flag_in;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_link;
  logic [31:0] res_link_addr;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken;
  logic [15:0] stat_not_taken;
`endif

  branch_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .alu_issue       (alu_issue),
    .alu_issue_ready (alu_issue_ready),
    .flag_valid      (flag_valid),
    .flag_in         (flag_in),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .br_cond         (br_cond),
    .br_pc           (br_pc),
    .br_offset       (br_offset),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_link        (res_link),
    .res_link_addr   (res_link_addr)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken      (stat_taken),
    .stat_not_taken  (stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  int         m_out;
  logic [2:0] m_flag;
  int         m_st_t;
  int         m_st_n;

  function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
    logic t;
    case (c)
      3'b000:  t = 1'b1;
      3'b001:  t = f[2];
      3'b010:  t = f[1];
      3'b011:  t = !f[1];
      3'b100:  t = f[0];
      3'b101:  t = !f[0];
      3'b110:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic bit ref_dep(input logic [2:0] c);
    return !(c == 3'b000 || c == 3'b110 || c == 3'b111);
  endfunction

  // Advance one clock, updating the model from the inputs driven this cycle
  task automatic step();
    int inc;
    int dec;
    inc = (alu_issue && m_out < 3) ? 1 : 0;
    dec = (flag_valid && m_out > 0) ? 1 : 0;
    m_out = m_out + inc - dec;
    if (flag_valid) m_flag = flag_in;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out  = 0;
    m_flag = 3'b000;
    m_st_t = 0;
    m_st_n = 0;
  endtask

  task automatic issue_ops(input int n);
    for (int i = 0; i < n; i++) begin
      alu_issue = 1'b1;
      step();
      alu_issue = 1'b0;
    end
  endtask

  task automatic drain();
    while (m_out > 0) begin
      flag_valid = 1'b1;
      flag_in    = 3'($urandom);
      step();
      flag_valid = 1'b0;
    end
  endtask

  // One full branch transaction: accept, optional flag delivery, hold, handshake
  task automatic do_branch(input logic [2:0] cond, input logic [31:0] pc,
                           input logic [31:0] off, input bit acc_alu,
                           input logic [2:0] fl_mid, input logic [2:0] fl_last,
                           input int gap, input int hold);
    int          snap;
    int          waits;
    logic [2:0]  exp_flags;
    logic        exp_tk;
    logic        exp_lk;
    logic [31:0] exp_tgt;
    logic [31:0] exp_la;

    total++;
    if (br_ready !== 1'b1) begin
      bad++;
      $display("FAIL br_ready_before_accept got=%b exp=1", br_ready);
    end
    snap      = m_out;
    exp_flags = m_flag;
    br_valid  = 1'b1;
    br_cond   = cond;
    br_pc     = pc;
    br_offset = off;
    alu_issue = acc_alu;
    step();
    br_valid  = 1'b0;
    alu_issue = 1'b0;
    br_cond   = 3'($urandom);
    br_pc     = $urandom;
    br_offset = $urandom;

    waits = ref_dep(cond) ? snap : 0;
    if (waits > 0) begin
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL res_valid_early got=%b exp=0 cond=%0d", res_valid, cond);
      end
      for (int i = 0; i < waits; i++) begin
        if (i > 0) begin
          for (int g = 0; g < gap; g++) step();
        end
        flag_valid = 1'b1;
        flag_in    = (i == waits - 1) ? fl_last : fl_mid;
        step();
        flag_valid = 1'b0;
        total++;
        if (res_valid !== 1'b0) begin
          bad++;
          $display("FAIL res_valid_wait got=%b exp=0 flag#=%0d", res_valid, i);
        end
      end
      exp_flags = m_flag;
      step();
    end

    exp_tk  = ref_taken(cond, exp_flags);
    exp_lk  = (cond == 3'b110);
    exp_tgt = pc + off;
    exp_la  = pc + 32'd4;

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) step();
      total++;
      if (res_valid !== 1'b1 || res_taken !== exp_tk || res_link !== exp_lk ||
          res_target !== exp_tgt || res_link_addr !== exp_la || br_ready !== 1'b0) begin
        bad++;
        $display("FAIL resp cond=%0d cyc=%0d got v=%b t=%b l=%b tgt=%h la=%h rdy=%b exp v=1 t=%b l=%b tgt=%h la=%h rdy=0",
                 cond, h, res_valid, res_taken, res_link, res_target, res_link_addr, br_ready,
                 exp_tk, exp_lk, exp_tgt, exp_la);
      end
    end

    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    if (exp_tk) begin
      if (m_st_t < 65535) m_st_t++;
    end else begin
      if (m_st_n < 65535) m_st_n++;
    end
    total++;
    if (res_valid !== 1'b0 || br_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_handshake got v=%b rdy=%b exp v=0 rdy=1", res_valid, br_ready);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    alu_issue  = 1'b0;
    flag_valid = 1'b0;
    flag_in    = 3'b000;
    br_valid   = 1'b0;
    br_cond    = 3'b000;
    br_pc      = 32'd0;
    br_offset  = 32'd0;
    res_ready  = 1'b0;
    model_reset();
    #2;
    repeat (3) begin
      total++;
      if (br_ready !== 1'b0 || res_valid !== 1'b0 || res_taken !== 1'b0 || res_link !== 1'b0 ||
          res_target !== 32'd0 || res_link_addr !== 32'd0 || alu_issue_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_values got rdy=%b v=%b t=%b l=%b tgt=%h la=%h air=%b",
                 br_ready, res_valid, res_taken, res_link, res_target, res_link_addr, alu_issue_ready);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    total++;
    if (br_ready !== 1'b1) begin
      bad++;
      $display("FAIL br_ready_after_reset got=%b exp=1", br_ready);
    end
  endtask

  task automatic test_always_branch();
    do_branch(3'b000, 32'h0000_0100, 32'h0000_0040, 1'b0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic test_bz_later_flags();
    issue_ops(2);
    do_branch(3'b010, 32'h0000_2000, 32'h0000_0010, 1'b0, 3'b010, 3'b000, 3, 0);
    issue_ops(2);
    do_branch(3'b010, 32'h0000_2000, 32'h0000_0010, 1'b0, 3'b010, 3'b010, 3, 0);
  endtask

  task automatic test_bl_wrap();
    do_branch(3'b110, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic test_backpressure();
    // bcy accepted with nothing outstanding while a younger op issues
    do_branch(3'b100, 32'h0000_4000, 32'hFFFF_FFF0, 1'b1, 3'b000, 3'b000, 0, 5);
    total++;
    if (alu_issue_ready !== 1'b1 || m_out != 1) begin
      bad++;
      $display("FAIL younger_issue_counted got air=%b model_out=%0d exp air=1 out=1", alu_issue_ready, m_out);
    end
    drain();
  endtask

  task automatic test_counter_full();
    issue_ops(3);
    total++;
    if (alu_issue_ready !== 1'b0) begin
      bad++;
      $display("FAIL alu_issue_ready_full got=%b exp=0", alu_issue_ready);
    end
    issue_ops(1);
    total++;
    if (alu_issue_ready !== 1'b0) begin
      bad++;
      $display("FAIL fourth_issue_ignored got=%b exp=0", alu_issue_ready);
    end
    drain();
    total++;
    if (alu_issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL alu_issue_ready_drained got=%b exp=1", alu_issue_ready);
    end
    // Nothing outstanding now: a flag-dependent branch must not wait
    do_branch(3'b011, 32'h0000_0800, 32'h0000_0100, 1'b0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    issue_ops(1);
    br_valid = 1'b1;
    br_cond  = 3'b010;
    br_pc    = 32'h0000_3000;
    br_offset = 32'h0000_0020;
    step();
    br_valid = 1'b0;
    total++;
    if (res_valid !== 1'b0 || br_ready !== 1'b0) begin
      bad++;
      $display("FAIL in_wait got v=%b rdy=%b exp v=0 rdy=0", res_valid, br_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0 || br_ready !== 1'b0 || alu_issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_wait got v=%b rdy=%b air=%b exp v=0 rdy=0 air=1", res_valid, br_ready, alu_issue_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    do_branch(3'b000, 32'h0000_5000, 32'h0000_0004, 1'b0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_branch(3'b111, 32'h0000_6000, 32'h0000_0100, 1'b0, 3'b000, 3'b000, 0, 0);
    do_branch(3'b110, 32'h0000_7000, 32'h0000_0200, 1'b0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int n;
      bit acc;
      n   = $urandom_range(0, 3);
      issue_ops(n);
      acc = (n < 3) && ($urandom_range(0, 3) == 0);
      do_branch(3'($urandom), $urandom, $urandom, acc, 3'($urandom), 3'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
      drain();
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    test_reset();
    total++;
    if (stat_taken !== 16'd0 || stat_not_taken !== 16'd0) begin
      bad++;
      $display("FAIL stats_reset got t=%0d n=%0d exp 0 0", stat_taken, stat_not_taken);
    end
    for (int i = 0; i < 3; i++) do_branch(3'b000, $urandom, $urandom, 1'b0, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 2; i++) do_branch(3'b111, $urandom, $urandom, 1'b0, 3'b000, 3'b000, 0, 1);
    total++;
    if (stat_taken !== 16'd3 || stat_not_taken !== 16'd2) begin
      bad++;
      $display("FAIL stats_counts got t=%0d n=%0d exp 3 2", stat_taken, stat_not_taken);
    end
    test_random();
    total++;
    if (stat_taken !== 16'(m_st_t) || stat_not_taken !== 16'(m_st_n)) begin
      bad++;
      $display("FAIL stats_random got t=%0d n=%0d exp %0d %0d", stat_taken, stat_not_taken, m_st_t, m_st_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_always_branch();
    test_bz_later_flags();
    test_bl_wrap();
    test_backpressure();
    test_counter_full();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Shall have one clock and an asynchronous, active-high reset: clk input 1 (rising edge) and rst input 1.
REQ-002 Ports shall be, as name direction width meaning:
- alu_issue  in  1  a flag-setting ALU op entered execute
- alu_issue_ready  out  1  outstanding-flag counter not full
- flag_valid  in  1  ALU flags for the oldest outstanding op are valid
- flag_in  in  3  {sign,zero,carry}
- br_valid  in  1  branch request valid
- br_ready  out  1  unit can accept a branch
- br_cond  in  3  condition code
- br_pc  in  32  branch PC
- br_offset  in  32  byte offset
- res_valid  out  1  resolution valid
- res_ready  in  1  consumer accepts the resolution
- res_taken  out  1  branch taken
- res_target  out  32  target PC
- res_link  out  1  write link register
- res_link_addr  out  32  return address

Function
REQ-003 Condition codes shall be:
- 000 br: always
- 001 bltz: sign
- 010 bz: zero
- 011 bnz: !zero
- 100 bcy: carry
- 101 bncy: !carry
- 110 bl: always, with link
- 111: reserved, not taken, no link
REQ-004 Codes 000, 110 and 111 shall be flag-independent; all other codes are flag-dependent.
REQ-005 flag_q shall load flag_in on every cycle with flag_valid, in any state.
REQ-006 Outstanding counter out_cnt (2-bit) handling:
- +1 on alu_issue only
- -1 on flag_valid only
- unchanged when both occur
- stays 0 on a stray flag_valid
REQ-007 alu_issue_ready shall equal (out_cnt != 3), and alu_issue while out_cnt==3 shall be ignored.
REQ-008 FSM states shall be IDLE, WAIT, RESP; br_ready shall be 1 only in IDLE.
REQ-009 On IDLE with br_valid, the unit shall capture the request and snapshot wait_cnt = pre-edge out_cnt.
- alu_issue in the accept cycle is younger and is excluded from the snapshot.
REQ-010 After accept:
- flag-independent code, or wait_cnt==0: go to RESP, evaluating with pre-edge flag_q
- otherwise: go to WAIT
REQ-011 In WAIT, each flag_valid shall decrement wait_cnt.
- On the edge where wait_cnt is already 0, the FSM goes to RESP and evaluates with flag_q.
- Response appears 2 cycles after the last required flag_valid.
REQ-012 Resolution outputs:
- res_target = br_pc + br_offset, modulo 2^32 (wrap, no carry out)
- res_link_addr = br_pc + 4, modulo 2^32
- res_link = (cond==110)
REQ-013 All res_* outputs shall be registered and held stable while res_valid=1.
REQ-014 In RESP, res_valid=1 until res_ready=1, then return to IDLE; a new request cannot be accepted in that same cycle.
REQ-015 Minimum latency shall be 1 cycle from accept to res_valid, with a throughput of one branch per 2 cycles.

Reset
REQ-016 While rst=1:
- state=IDLE
- out_cnt=0, wait_cnt=0, flag_q=000
- res_valid=0, res_taken=0, res_link=0, res_target=0, res_link_addr=0
- br_ready=0 during reset, 1 after
REQ-017 Reset mid-operation shall discard any captured branch and any pending response.

Configuration
REQ-018 With BRANCH_STATS_EN defined, the unit shall add outputs stat_taken and stat_not_taken (16 bits each).
- Counted at each RESP handshake.
- Saturate at 16'hFFFF.
- Cleared by rst.
REQ-019 Without BRANCH_STATS_EN, these ports and counters shall not exist and behaviour shall otherwise be identical.

Structure
REQ-020 A shared package shall hold:
- condition-code constants
- flag bit indices (SIGN=2, ZERO=1, CARRY=0)
- FSM state encoding
REQ-021 A combinational sub-module branch_cond_eval shall map (cond, flags) to (taken, link).

Verification
REQ-022 br, cond=000, pc=0x100, offset=0x40, out_cnt=0 -> next cycle res_valid=1, taken=1, target=0x140, link=0.
REQ-023 bz, with out_cnt=2 at accept:
- flag_valid flag_in=010, then 3 idle cycles, then flag_valid 000 -> resolves not taken (later flags win).
- Same sequence with final flags 010 -> taken.
REQ-024 bl, pc=0xFFFFFFFC, offset=8 -> target=0x00000004, link_addr=0x00000000, link=1, taken=1.
REQ-025 Hold res_ready=0 for 5 cycles -> res_* stable, br_ready=0; alu_issue in the accept cycle of bcy -> not waited on.
REQ-026 Issue 4 alu_issue with no flags -> alu_issue_ready=0 at 3 and the 4th is ignored; rst asserted in WAIT -> IDLE, res_valid=0.
REQ-027 With BRANCH_STATS_EN: 3 taken and 2 not-taken handshakes -> stat_taken=3, stat_not_taken=2.
